// File: rtl/qspi_psram_dev.sv
// QSPI/QPI PSRAM device model: SPI power-up, QPI mode switch, read/write/ID/reset commands.
// Define QSPI_PSRAM_PAGE_WRAP_EN to wrap burst addresses within a PAGE_SIZE page.
module qspi_psram_dev #(
    parameter int unsigned DEPTH        = 128,
    parameter int unsigned ADR_BYTES    = 3,
    parameter int unsigned DUMMY_CYCLES = 4,
    parameter int unsigned PAGE_SIZE    = 32,
    parameter logic [15:0] DEV_ID       = 16'h0D5D
) (
    input  logic       sck_i,
    input  logic       rst_in,
    input  logic       cs_in,
    input  logic [3:0] io_i,
    output logic [3:0] io_o,
    output logic [3:0] io_oe_o,
    output logic       qpi_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] SPI_ADR_LAST = 8'(ADR_BYTES * 8 - 1);
    localparam logic [7:0] QPI_ADR_LAST = 8'(ADR_BYTES * 2 - 1);

    if (PAGE_SIZE > DEPTH || PAGE_SIZE == 0) begin : g_bad_page
        $error("PAGE_SIZE must be a nonzero power of two not larger than DEPTH");
    end

    typedef enum logic [2:0] {StCmd, StAdr, StDummy, StRead, StWrite, StIdle} state_e;

    state_e        r_state;
    logic [7:0]    r_cnt;
    logic [7:0]    r_cmd;
    logic [7:0]    r_wdat;
    logic [7:0]    r_dum;
    logic [AW-1:0] r_adr;
    logic          r_wr;
    logic          r_id;
    logic          r_qpi;
    logic          r_prev66;
    logic [3:0]    r_io_o;
    logic [3:0]    r_io_oe;
    logic [7:0]    r_mem [DEPTH];

    logic          w_byte_last;
    logic [7:0]    w_cmd;
    logic [7:0]    w_wbyte;
    logic [AW-1:0] w_adr_nx;
    logic [AW-1:0] w_adr_inc;
    logic [AW-1:0] w_adr_step;
    logic          w_cmd_done;
    logic          w_we;
    logic [7:0]    w_rbyte;
    logic          w_rbit;

    assign w_byte_last = r_qpi ? r_cnt[0] : (r_cnt[2:0] == 3'd7);
    assign w_cmd       = r_qpi ? {r_cmd[3:0], io_i} : {r_cmd[6:0], io_i[0]};
    assign w_wbyte     = r_qpi ? {r_wdat[3:0], io_i} : {r_wdat[6:0], io_i[0]};
    assign w_adr_nx    = r_qpi ? AW'({r_adr, io_i}) : AW'({r_adr, io_i[0]});
    assign w_cmd_done  = !cs_in && (r_state == StCmd) && w_byte_last;
    assign w_we        = !cs_in && (r_state == StWrite) && w_byte_last;

`ifdef QSPI_PSRAM_PAGE_WRAP_EN
    localparam logic [AW-1:0] PMASK = AW'(PAGE_SIZE - 1);
    assign w_adr_inc = (r_adr & ~PMASK) | ((r_adr + 1'b1) & PMASK);
`else
    assign w_adr_inc = r_adr + 1'b1;
`endif

    // In ID reads the address register is a byte index that parks on the 0xFF filler.
    assign w_adr_step = r_id ? ((r_adr == AW'(2)) ? r_adr : r_adr + 1'b1) : w_adr_inc;
    assign w_rbyte    = r_id ? ((r_adr == '0) ? DEV_ID[15:8] :
                                (r_adr == AW'(1)) ? DEV_ID[7:0] : 8'hFF)
                             : r_mem[r_adr];
    assign w_rbit     = w_rbyte[~r_cnt[2:0]];

    always_ff @(posedge sck_i or negedge rst_in or posedge cs_in) begin
        if (!rst_in || cs_in) begin
            r_state <= StCmd;
            r_cnt   <= '0;
            r_cmd   <= '0;
            r_wdat  <= '0;
            r_dum   <= '0;
            r_adr   <= '0;
            r_wr    <= 1'b0;
            r_id    <= 1'b0;
        end else begin
            case (r_state)
                StCmd: begin
                    r_cmd <= w_cmd;
                    if (w_byte_last) begin
                        r_cnt   <= '0;
                        r_wr    <= 1'b0;
                        r_id    <= 1'b0;
                        r_dum   <= '0;
                        r_adr   <= '0;
                        r_state <= StIdle;
                        if (!r_qpi) begin
                            case (w_cmd)
                                8'h03: r_state <= StAdr;
                                8'h0B: begin r_state <= StAdr; r_dum <= 8'd8; end
                                8'h02: begin r_state <= StAdr; r_wr <= 1'b1; end
                                8'h9F: begin r_state <= StRead; r_id <= 1'b1; end
                                default: r_state <= StIdle;
                            endcase
                        end else begin
                            case (w_cmd)
                                8'h0B: begin r_state <= StAdr; r_dum <= 8'(DUMMY_CYCLES); end
                                8'h02, 8'h38: begin r_state <= StAdr; r_wr <= 1'b1; end
                                default: r_state <= StIdle;
                            endcase
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StAdr: begin
                    r_adr <= w_adr_nx;
                    if (r_cnt == (r_qpi ? QPI_ADR_LAST : SPI_ADR_LAST)) begin
                        r_cnt   <= '0;
                        r_state <= r_wr ? StWrite : ((r_dum == '0) ? StRead : StDummy);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StDummy: begin
                    if (r_cnt == r_dum - 1'b1) begin
                        r_cnt   <= '0;
                        r_state <= StRead;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StRead, StWrite: begin
                    if (r_state == StWrite) r_wdat <= w_wbyte;
                    if (w_byte_last) begin
                        r_cnt <= '0;
                        r_adr <= w_adr_step;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Mode and reset-enable history survive chip-select; only rst_in clears them.
    always_ff @(posedge sck_i or negedge rst_in) begin
        if (!rst_in) begin
            r_qpi    <= 1'b0;
            r_prev66 <= 1'b0;
        end else if (w_cmd_done) begin
            r_prev66 <= (w_cmd == 8'h66);
            if (!r_qpi && w_cmd == 8'h35)       r_qpi <= 1'b1;
            else if (r_qpi && w_cmd == 8'hF5)   r_qpi <= 1'b0;
            else if (w_cmd == 8'h99 && r_prev66) r_qpi <= 1'b0;
        end
    end

    always_ff @(posedge sck_i) begin
        if (w_we) r_mem[r_adr] <= w_wbyte;
    end

    always_ff @(negedge sck_i or negedge rst_in or posedge cs_in) begin
        if (!rst_in || cs_in) begin
            r_io_o  <= 4'h0;
            r_io_oe <= 4'h0;
        end else if (r_state == StRead) begin
            r_io_oe <= r_qpi ? 4'hF : 4'b0010;
            r_io_o  <= r_qpi ? (r_cnt[0] ? w_rbyte[3:0] : w_rbyte[7:4])
                             : {2'b00, w_rbit, 1'b0};
        end else begin
            r_io_oe <= 4'h0;
        end
    end

    assign io_o    = r_io_o;
    assign io_oe_o = r_io_oe;
    assign qpi_o   = r_qpi;

endmodule

// File: tb/tb_qspi_psram_dev.sv
// Directed bench for qspi_psram_dev: ID, SPI/QPI read/write, page wrap, abort, mode and reset.
module tb_qspi_psram_dev;

    logic       sck, rst_n, cs_n, qpi;
    logic [3:0] io_i, io_o, io_oe;
    logic [3:0] last_oe;
    logic [7:0] rb;
    logic [3:0] nib;
    int         n_checks, n_errors;
    bit         bench_qpi;

    qspi_psram_dev dut (
        .sck_i   (sck),
        .rst_in  (rst_n),
        .cs_in   (cs_n),
        .io_i    (io_i),
        .io_o    (io_o),
        .io_oe_o (io_oe),
        .qpi_o   (qpi)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One SCK period; outputs sampled while SCK is low, just before the sampling edge.
    task automatic cyc(input logic [3:0] d, output logic [3:0] o);
        io_i = d;
        #4;
        o = io_o;
        last_oe = io_oe;
        #1 sck = 1'b1;
        #5 sck = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b);
        logic [3:0] o;
        if (bench_qpi) begin
            cyc(b[7:4], o);
            cyc(b[3:0], o);
        end else begin
            for (int i = 7; i >= 0; i--) cyc({3'b000, b[i]}, o);
        end
    endtask

    task automatic get_byte(output logic [7:0] b);
        logic [3:0] o;
        if (bench_qpi) begin
            cyc(4'h0, o); b[7:4] = o;
            cyc(4'h0, o); b[3:0] = o;
        end else begin
            for (int i = 7; i >= 0; i--) begin
                cyc(4'h0, o);
                b[i] = o[1];
            end
        end
    endtask

    task automatic start(input logic [7:0] cmd);
        cs_n = 1'b0;
        #5;
        put_byte(cmd);
    endtask

    task automatic stop();
        #5 cs_n = 1'b1;
        #5;
    endtask

    task automatic put_adr(input logic [23:0] a);
        put_byte(a[23:16]);
        put_byte(a[15:8]);
        put_byte(a[7:0]);
    endtask

    task automatic dummies(input int n);
        logic [3:0] o;
        for (int i = 0; i < n; i++) cyc(4'h0, o);
    endtask

    task automatic wr1(input logic [23:0] a, input logic [7:0] d);
        start(8'h02); put_adr(a); put_byte(d); stop();
    endtask

    // QPI fast read of one byte.
    task automatic qrd1(input logic [23:0] a, output logic [7:0] d);
        start(8'h0B); put_adr(a); dummies(4); get_byte(d); stop();
    endtask

    initial begin
        sck = 1'b0; cs_n = 1'b1; io_i = 4'h0; rst_n = 1'b0;
        n_checks = 0; n_errors = 0; bench_qpi = 1'b0;
        #5;
        check("rst_io_o", 32'(io_o), 32'h0);
        check("rst_oe", 32'(io_oe), 32'h0);
        check("rst_qpi", 32'(qpi), 32'h0);
        #5 rst_n = 1'b1;
        #5;

        // SPI read ID
        start(8'h9F);
        get_byte(rb); check("id0", 32'(rb), 32'h0D);
        check("id_oe", 32'(last_oe), 32'h2);
        get_byte(rb); check("id1", 32'(rb), 32'h5D);
        get_byte(rb); check("id_fill", 32'(rb), 32'hFF);
        stop();
        check("id_oe_off", 32'(io_oe), 32'h0);

        // SPI write then read, zero dummies
        start(8'h02); put_adr(24'h000010); put_byte(8'hA5); put_byte(8'h3C); stop();
        start(8'h03); put_adr(24'h000010);
        get_byte(rb); check("spi_rd0", 32'(rb), 32'hA5);
        get_byte(rb); check("spi_rd1", 32'(rb), 32'h3C);
        stop();

        // SPI fast read with 8 dummies
        start(8'h0B); put_adr(24'h000011); dummies(8);
        get_byte(rb); check("spi_fast", 32'(rb), 32'h3C);
        stop();

        start(8'h35); stop();
        check("qpi_on", 32'(qpi), 32'h1);
        bench_qpi = 1'b1;

        // QPI burst across the page boundary
        wr1(24'h000000, 8'h5A);
        wr1(24'h000020, 8'h6B);
        start(8'h38); put_adr(24'h00001F); put_byte(8'h11); put_byte(8'h22); stop();
        start(8'h0B); put_adr(24'h00001F); dummies(4);
        get_byte(rb); check("qrd0", 32'(rb), 32'h11);
        check("qrd_oe", 32'(last_oe), 32'hF);
        get_byte(rb); check("qrd1", 32'(rb), 32'h22);
        stop();
`ifdef QSPI_PSRAM_PAGE_WRAP_EN
        qrd1(24'h000000, rb); check("wrap_at0", 32'(rb), 32'h22);
        qrd1(24'h000020, rb); check("wrap_at20", 32'(rb), 32'h6B);
`else
        qrd1(24'h000000, rb); check("lin_at0", 32'(rb), 32'h5A);
        qrd1(24'h000020, rb); check("lin_at20", 32'(rb), 32'h22);
`endif

        // Partial byte discarded at chip-select rise
        start(8'h02); put_adr(24'h000005); put_byte(8'h44); put_byte(8'h55); stop();
        start(8'h02); put_adr(24'h000005);
        cyc(4'h7, nib); cyc(4'h8, nib); cyc(4'h9, nib);
        stop();
        qrd1(24'h000005, rb); check("part_m5", 32'(rb), 32'h78);
        qrd1(24'h000006, rb); check("part_m6", 32'(rb), 32'h55);

        // Chip-select abort mid read drops OE with SCK stopped
        start(8'h0B); put_adr(24'h000010); dummies(4);
        cyc(4'h0, nib);
        check("abort_nib", 32'(nib), 32'hA);
        cs_n = 1'b1;
        #1 check("abort_oe", 32'(io_oe), 32'h0);
        #5;

        // Reset command handling
        start(8'h99); stop();
        check("rst99_alone", 32'(qpi), 32'h1);
        start(8'h66); stop();
        start(8'h99); stop();
        check("rst66_99", 32'(qpi), 32'h0);
        bench_qpi = 1'b0;
        start(8'h35); stop();
        check("qpi_on2", 32'(qpi), 32'h1);
        bench_qpi = 1'b1;
        start(8'hF5); stop();
        check("qpi_exit", 32'(qpi), 32'h0);
        bench_qpi = 1'b0;
        start(8'h35); stop();
        bench_qpi = 1'b1;

        // Async reset mid QPI read
        start(8'h0B); put_adr(24'h000010); dummies(4);
        cyc(4'h0, nib);
        rst_n = 1'b0;
        #1;
        check("arst_oe", 32'(io_oe), 32'h0);
        check("arst_qpi", 32'(qpi), 32'h0);
        #4 rst_n = 1'b1;
        stop();
        bench_qpi = 1'b0;
        start(8'h03); put_adr(24'h000010);
        get_byte(rb); check("post_rst0", 32'(rb), 32'hA5);
        get_byte(rb); check("post_rst1", 32'(rb), 32'h3C);
        stop();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
